// File: rtl/alu_mul_seq_if.sv
// Interface bundle for alu_mul_seq: pipeline request/response plus shared alu drive.
// master = environment (pipeline + alu), slave = the sequential multiplier.
interface alu_mul_seq_if;
  localparam int unsigned W    = 16;
  localparam int unsigned CMDW = 3;

  logic            start;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic            busy;
  logic            done;
  logic [W-1:0]    product;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [CMDW-1:0] alu_cmd;
  logic [W-1:0]    alu_r;

  modport master (
    output start, op_a, op_b, alu_r,
    input  busy, done, product, alu_a, alu_b, alu_cmd
  );

  modport slave (
    input  start, op_a, op_b, alu_r,
    output busy, done, product, alu_a, alu_b, alu_cmd
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16x16 unsigned shift-add multiplier (low 16 bits) that borrows the
// shared alu for every add/shift. One iteration = ADD, SHL, SHR (3 cycles).
// Optional macro MUL_EARLY_EXIT_EN: finish as soon as the multiplier shifts to zero.
module alu_mul_seq (
  input  logic          clk,
  input  logic          rst,
  alu_mul_seq_if.slave  bus
);
  localparam int unsigned W    = 16;
  localparam int unsigned CNTW = 4;
  localparam int unsigned CMDW = 3;

  // alu command codes shared with the mips_16 alu
  localparam logic [CMDW-1:0] ALU_ADD = 3'd1;
  localparam logic [CMDW-1:0] ALU_SL  = 3'd6;
  localparam logic [CMDW-1:0] ALU_SRU = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    product_q, product_d;
  logic            busy_q, done_q;
  logic            last_iter_c;

  // State and datapath registers; busy/done are decoded from the next state so they are flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= (state_d == S_ADD) || (state_d == S_SHL) || (state_d == S_SHR);
      done_q    <= (state_d == S_DONE);
    end
  end

  // Alu operand select; idle drives a harmless 0+0 add so alu r is never X.
  always_comb begin
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_cmd = ALU_ADD;
    case (state_q)
      S_ADD: begin
        bus.alu_a = acc_q;
        bus.alu_b = mplier_q[0] ? mcand_q : '0;
      end
      S_SHL: begin
        bus.alu_a   = mcand_q;
        bus.alu_b   = W'(1);
        bus.alu_cmd = ALU_SL;
      end
      S_SHR: begin
        bus.alu_a   = mplier_q;
        bus.alu_b   = W'(1);
        bus.alu_cmd = ALU_SRU;
      end
      default: ;
    endcase
  end

  // Loop termination: fixed 16 iterations, or earlier once the multiplier is exhausted.
`ifdef MUL_EARLY_EXIT_EN
  assign last_iter_c = (cnt_q == CNTW'(15)) || (bus.alu_r == '0);
`else
  assign last_iter_c = (cnt_q == CNTW'(15));
`endif

  // Next-state and register updates; alu result is captured in the same cycle it is issued.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          mcand_d  = bus.op_a;
          mplier_d = bus.op_b;
          cnt_d    = '0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        acc_d   = bus.alu_r;
        state_d = S_SHL;
      end
      S_SHL: begin
        mcand_d = bus.alu_r;
        state_d = S_SHR;
      end
      S_SHR: begin
        mplier_d = bus.alu_r;
        cnt_d    = cnt_q + CNTW'(1);
        if (last_iter_c) begin
          product_d = acc_q;
          state_d   = S_DONE;
        end else begin
          state_d = S_ADD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural alu attached to alu_*.
// Honours MUL_EARLY_EXIT_EN for expected latency.
module tb_alu_mul_seq;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SL  = 3'd6;
  localparam logic [2:0] ALU_SRU = 3'd7;

  logic clk = 1'b0;
  logic rst;
  bit   hold_start;
  int   total = 0;
  int   bad   = 0;

  alu_mul_seq_if bus ();

  alu_mul_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared alu (combinational return)
  always_comb begin
    case (bus.alu_cmd)
      ALU_ADD: bus.alu_r = 16'(bus.alu_a + bus.alu_b);
      ALU_SL:  bus.alu_r = 16'(bus.alu_a << bus.alu_b);
      ALU_SRU: bus.alu_r = 16'(bus.alu_a >> bus.alu_b);
      default: bus.alu_r = 16'hxxxx;
    endcase
  end

  // Expected cycles from the accept edge to the done cycle
  function automatic int exp_lat(input logic [15:0] b);
    int top;
    top = 0;
`ifdef MUL_EARLY_EXIT_EN
    for (int i = 0; i < 16; i++) if (b[i]) top = i;
    return 3 * (top + 1) + 1;
`else
    top = int'(b[0]) * 0;
    return 49 + top;
`endif
  endfunction

  function automatic logic [15:0] exp_prod(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] full;
    full = 32'(a) * 32'(b);
    return full[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request on the next negedge; accepted at the following posedge (edge N)
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
  endtask

  // Observe cycles N+1..N+ncyc at negedges; optionally re-request at cycle inj
  task automatic watch(input int ncyc, input int inj, input logic [15:0] ia, input logic [15:0] ib,
                       output int d1, output int d2, output int ndone, output int nbusy,
                       output int overlap, output logic [15:0] p1, output logic [15:0] p2);
    d1 = -1; d2 = -1; ndone = 0; nbusy = 0; overlap = 0; p1 = 'x; p2 = 'x;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) nbusy++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
      if (bus.done === 1'b1) begin
        ndone++;
        if (d1 < 0) begin d1 = c; p1 = bus.product; end
        else if (d2 < 0) begin d2 = c; p2 = bus.product; end
      end
      if (c == inj) begin
        bus.start = 1'b1;
        bus.op_a  = ia;
        bus.op_b  = ib;
      end else begin
        bus.start = hold_start;
        bus.op_a  = 16'($urandom);
        bus.op_b  = 16'($urandom);
      end
    end
  endtask

  task automatic run_one(input logic [15:0] a, input logic [15:0] b);
    int d1, d2, nd, nb, ov;
    logic [15:0] p1, p2;
    string t;
    t = $sformatf("%h*%h", a, b);
    launch(a, b);
    watch(60, 0, 16'h0, 16'h0, d1, d2, nd, nb, ov, p1, p2);
    check({t, " done_cycle"}, 32'(d1), 32'(exp_lat(b)));
    check({t, " busy_cycles"}, 32'(nb), 32'(exp_lat(b) - 1));
    check({t, " done_pulses"}, 32'(nd), 32'd1);
    check({t, " busy_and_done"}, 32'(ov), 32'd0);
    check({t, " product_at_done"}, 32'(p1), 32'(exp_prod(a, b)));
    check({t, " product_held"}, 32'(bus.product), 32'(exp_prod(a, b)));
  endtask

  initial begin
    int d1, d2, nd, nb, ov;
    logic [15:0] p1, p2, ra, rb;

    rst = 1'b1; hold_start = 1'b0;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset product", 32'(bus.product), 32'd0);
    check("reset alu_cmd", 32'(bus.alu_cmd), 32'(ALU_ADD));
    check("reset alu_a", 32'(bus.alu_a), 32'd0);
    check("reset alu_b", 32'(bus.alu_b), 32'd0);
    rst = 1'b0;

    run_one(16'd3, 16'd5);
    run_one(16'hFFFF, 16'hFFFF);
    run_one(16'h0100, 16'h0100);
    run_one(16'h1234, 16'h0000);

    // second request while busy is dropped
    launch(16'd3, 16'd5);
    watch(60, 10, 16'd7, 16'd7, d1, d2, nd, nb, ov, p1, p2);
    check("ignore done_pulses", 32'(nd), 32'd1);
    check("ignore done_cycle", 32'(d1), 32'(exp_lat(16'd5)));
    check("ignore product", 32'(bus.product), 32'd15);

    // reset in the middle of a run
    launch(16'd3, 16'd5);
    watch(19, 0, 16'h0, 16'h0, d1, d2, nd, nb, ov, p1, p2);
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst product", 32'(bus.product), 32'd0);
    check("midrst alu_cmd", 32'(bus.alu_cmd), 32'(ALU_ADD));
    rst = 1'b0;
    run_one(16'd6, 16'd7);

    // back-to-back with start held high
    hold_start = 1'b1;
    launch(16'd2, 16'd3);
    watch(2 * 50 + 5, exp_lat(16'd3) + 1, 16'd4, 16'd5, d1, d2, nd, nb, ov, p1, p2);
    hold_start = 1'b0;
    bus.start  = 1'b0;
    check("b2b first_done", 32'(d1), 32'(exp_lat(16'd3)));
    check("b2b spacing", 32'(d2 - d1), 32'(1 + exp_lat(16'd5)));
    check("b2b product1", 32'(p1), 32'd6);
    check("b2b product2", 32'(p2), 32'd20);
    check("b2b busy_and_done", 32'(ov), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // random operands, with varied multiplier bit-lengths
    for (int k = 0; k < 10; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom >> $urandom_range(16, 31));
      run_one(ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
